// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
// One radix-2 iteration per cycle on operand magnitudes; signs are corrected in FIX.
module mips_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] operand;
  logic             neg_q, neg_r, is_div, div_zero;

  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_signed = 1'b0;
    if (SIGNED_EN && (op == OP_MULT || op == OP_DIV)) op_signed = 1'b1;
    a_neg = op_signed & a[WIDTH-1];
    b_neg = op_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ok    = ~div_diff[WIDTH];

    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
    // With b==0 the restoring loop leaves |a| in the remainder, so the dividend-sign fix yields raw a.
    rem_fix  = neg_r ? -acc_hi : acc_hi;
  end

  assign rd_data = rd_sel ? hi : lo;
  assign stall   = busy & (start | rd_req);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !cancel) begin
            unique case (op)
              OP_MULT, OP_MULTU: begin
                state    <= MUL;
                busy     <= 1'b1;
                count    <= '0;
                acc_hi   <= '0;
                acc_lo   <= b_mag;
                operand  <= a_mag;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= 1'b0;
                is_div   <= 1'b0;
                div_zero <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state    <= DIV;
                busy     <= 1'b1;
                count    <= '0;
                acc_hi   <= '0;
                acc_lo   <= a_mag;
                operand  <= b_mag;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                is_div   <= 1'b1;
                div_zero <= (b == '0);
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (state == MUL) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
              acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: scoreboard of expected {HI,LO} per op,
// popped and compared when done pulses; a second 8-bit unsigned instance covers SIGNED_EN=0.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, cancel, rd_req, rd_sel;
  logic [2:0]    op;
  logic [W-1:0]  a, b, rd_data;
  logic          busy, stall, done;

  logic          start8, cancel8, rd_req8, rd_sel8;
  logic [2:0]    op8;
  logic [7:0]    a8, b8, rd_data8;
  logic          busy8, stall8, done8;

  int tests  = 0;
  int failed = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done)
  );

  mips_muldiv_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(cancel8), .rd_req(rd_req8), .rd_sel(rd_sel8),
    .rd_data(rd_data8), .busy(busy8), .stall(stall8), .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb;
    int     qa, qb, q, r;
    logic [63:0] res;
    res = '0;
    case (mop)
      3'd0: begin sa = $signed(ma); sb = $signed(mb); res = sa * sb; end
      3'd1: res = {32'b0, ma} * {32'b0, mb};
      3'd2: begin
        if (mb == 0) res = {ma, 32'hFFFF_FFFF};
        else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          qa = $signed(ma); qb = $signed(mb);
          q = qa / qb; r = qa % qb;
          res = {r, q};
        end
      end
      default: begin
        if (mb == 0) res = {ma, 32'hFFFF_FFFF};
        else res = {ma % mb, ma / mb};
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    rd_sel = 1'b1; #1; h = rd_data;
    rd_sel = 1'b0; #1; l = rd_data;
  endtask

  // Issue one MULT/DIV op, wait for done, compare latency, single pulse and HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [63:0] exp, input string tag);
    int k;
    logic [31:0] h, l;
    logic [63:0] e;
    sb_q.push_back(exp);
    start = 1'b1; op = o; a = xa; b = xb;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    k = 0;
    do begin tick(); k++; end while (!done && k < 100);
    check({tag, "_latency"}, k, W + 1);
    check({tag, "_done"}, done, 1);
    e = sb_q.size() > 0 ? sb_q.pop_front() : 64'hx;
    read_hilo(h, l);
    check({tag, "_hi"}, h, e[63:32]);
    check({tag, "_lo"}, l, e[31:0]);
    tick();
    check({tag, "_pulse"}, done, 0);
  endtask

  task automatic idle_write(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; a = v;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k, n_done;
    logic [31:0] h, l;
    logic [63:0] e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 0; cancel = 0; rd_req = 0; rd_sel = 0; op = 0; a = 0; b = 0;
    start8 = 0; cancel8 = 0; rd_req8 = 0; rd_sel8 = 0; op8 = 0; a8 = 0; b8 = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    read_hilo(h, l);
    check("rst_hi", h, 0);
    check("rst_lo", l, 0);

    // Directed arithmetic vectors
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mult_m1x2");
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7_m2");
    run_op(3'd3, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, "divu_by0");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, "div_by0_neg");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i == 5) rb = rb >> 20;
      run_op(ro, ra, rb, model(ro, ra, rb), "rand");
    end

    // MFHI issued the cycle after start: stall until busy falls, then new HI visible
    sb_q.push_back(64'h0000_0003_0000_0000);
    start = 1'b1; op = 3'd1; a = 32'h8000_0000; b = 32'd6;
    tick();
    start = 1'b0; rd_req = 1'b1; rd_sel = 1'b1;
    k = 0;
    while (stall && k < 100) begin tick(); k++; end
    check("rd_stall_cycles", k, W + 1);
    e = sb_q.pop_front();
    check("rd_hi_new", rd_data, e[63:32]);
    rd_req = 1'b0;
    tick();

    // Start held while busy: ignored until busy falls, then accepted
    sb_q.push_back(64'h0000_0002_0000_000E);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    op = 3'd4; a = 32'h99;
    check("held_stall", stall, 1);
    k = 0;
    while (!done && k < 100) begin tick(); k++; end
    check("held_done", done, 1);
    check("held_stall_low", stall, 0);
    e = sb_q.pop_front();
    read_hilo(h, l);
    check("held_div_hi", h, e[63:32]);
    check("held_div_lo", l, e[31:0]);
    tick();
    start = 1'b0;
    read_hilo(h, l);
    check("held_mthi", h, 32'h99);
    check("held_busy", busy, 0);

    // MTLO in idle
    idle_write(3'd5, 32'h1234);
    check("mtlo_busy", busy, 0);
    check("mtlo_done", done, 0);
    read_hilo(h, l);
    check("mtlo_lo", l, 32'h1234);

    // Cancel mid-DIV
    idle_write(3'd4, 32'hA);
    idle_write(3'd5, 32'hB);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      tick();
    end
    check("cancel_no_done", n_done, 0);
    read_hilo(h, l);
    check("cancel_hi", h, 32'hA);
    check("cancel_lo", l, 32'hB);

    // Cancel with start in IDLE suppresses MTLO
    start = 1'b1; cancel = 1'b1; op = 3'd5; a = 32'h77;
    tick();
    start = 1'b0; cancel = 1'b0;
    read_hilo(h, l);
    check("cancel_idle_lo", l, 32'hB);

    // Cancel in the FIX cycle suppresses commit
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (W) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_fix_done", done, 0);
    check("cancel_fix_busy", busy, 0);
    read_hilo(h, l);
    check("cancel_fix_hi", h, 32'hA);
    check("cancel_fix_lo", l, 32'hB);

    // Reserved op: no effect
    idle_write(3'd6, 32'h5);
    check("rsvd_busy", busy, 0);
    read_hilo(h, l);
    check("rsvd_hilo", {h, l}, 64'h0000_000A_0000_000B);

    // 8-bit unsigned-only instance: MULT behaves as MULTU
    start8 = 1'b1; op8 = 3'd0; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!done8 && k < 100);
    check("w8_latency", k, 9);
    rd_sel8 = 1'b1; #1;
    check("w8_hi", rd_data8, 8'hFE);
    rd_sel8 = 1'b0; #1;
    check("w8_lo", rd_data8, 8'h01);
    tick();

    // Async reset mid-MUL
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd2;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    read_hilo(h, l);
    check("rst_mid_hilo", {h, l}, 64'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
